// File: rtl/hazard_unit.sv
// Hazard detection and front-end control for the 5-stage pipeline.
// Covers the hazards that forwarding cannot resolve: load-use, and branch
// operands still in flight. It also sequences the multi-cycle mul/div unit
// and keeps saturating stall and flush statistics.
module hazard_unit #(
  parameter int CNT_W      = 16,
  parameter int MD_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_IsMD,
  input  logic             IDEX_MemRd,
  input  logic             IDEX_RegWr,
  input  logic [4:0]       IDEX_Rd,
  input  logic             EXMEM_MemRd,
  input  logic [4:0]       EXMEM_Rd,
  input  logic             MD_Done,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic             MD_Timeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  localparam int TW = $clog2(MD_MAX_CYC + 1);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] scnt_q, fcnt_q;

  logic m_ex, m_mem, lu, br_ex, br_mem, stall;

  // Register r is an operand of the ID instruction ($0 never creates a hazard).
  assign m_ex   = (IDEX_Rd != 5'd0) &&
                  (IDEX_Rd == IFID_Rs || (ID_UsesRt && IDEX_Rd == IFID_Rt));
  assign m_mem  = (EXMEM_Rd != 5'd0) &&
                  (EXMEM_Rd == IFID_Rs || (ID_UsesRt && EXMEM_Rd == IFID_Rt));
  assign lu     = IDEX_MemRd && m_ex;
  assign br_ex  = ID_Branch && IDEX_RegWr && m_ex;
  assign br_mem = ID_Branch && EXMEM_MemRd && m_mem;
  assign stall  = lu | br_ex | br_mem;

  // Next-state and Mealy control outputs; reset forces the idle output set.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    to_d        = to_q;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    MD_Start    = 1'b0;
    MD_Busy     = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (stall) begin
            // Branch not resolved yet, so no flush while stalled.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
          end else begin
            if (ID_Branch && ID_BranchTaken) IFID_Flush = 1'b1;
            if (ID_IsMD) begin
              MD_Start = 1'b1;
              tcnt_d   = '0;
              state_d  = MD_WAIT;
            end
          end
        end
        MD_WAIT: begin
          MD_Busy = 1'b1;
          if (MD_Done) begin
            // Release in the Done cycle itself.
            state_d = RUN;
          end else begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            if (tcnt_q == TW'(MD_MAX_CYC - 1)) begin
              to_d    = 1'b1;
              state_d = RUN;
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, timeout tracking and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      to_q    <= 1'b0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
      if (IDEX_Bubble && scnt_q != '1) scnt_q <= scnt_q + CNT_W'(1);
      if (IFID_Flush && fcnt_q != '1)  fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign MD_Timeout = to_q & ~rst;
  assign StallCnt   = rst ? '0 : scnt_q;
  assign FlushCnt   = rst ? '0 : fcnt_q;
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Companion to the pipeline's forwarding unit. It detects the hazards that forwarding cannot resolve, and freezes or flushes the front end in response. It sits beside the ID stage and drives the PC write enable, the IF/ID write enable and flush, and bubble insertion into ID/EX. It also sequences the multi-cycle mul/div unit in EX with a start/done handshake, and keeps saturating counts of stalls and flushes.

Parameters:
CNT_W, 16, width of the StallCnt and FlushCnt statistics counters
MD_MAX_CYC, 64, number of MD_WAIT cycles after which MD_Timeout is raised

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
IFID_Rs  in  5  rs of the instruction in ID
IFID_Rt  in  5  rt of the instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
ID_Branch  in  1  ID instruction is a branch (compared in ID)
ID_BranchTaken  in  1  ID branch comparison result
ID_IsMD  in  1  ID instruction is a mul/div
IDEX_MemRd  in  1  EX instruction is a load
IDEX_RegWr  in  1  EX instruction writes a register
IDEX_Rd  in  5  EX destination register (after RegDst mux)
EXMEM_MemRd  in  1  MEM instruction is a load
EXMEM_Rd  in  5  MEM destination register
MD_Done  in  1  mul/div result valid (one-cycle pulse)
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register write enable
IDEX_Bubble  out  1  zero the control fields entering ID/EX
IFID_Flush  out  1  clear IF/ID (taken branch)
MD_Start  out  1  one-cycle start pulse to mul/div
MD_Busy  out  1  FSM is in MD_WAIT
MD_Timeout  out  1  sticky error flag
StallCnt  out  CNT_W  saturating count of bubble cycles
FlushCnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Operand match: M(r) is true when r != 0 and (r == IFID_Rs, or ID_UsesRt and r == IFID_Rt).
- LU (load-use hazard) = IDEX_MemRd && M(IDEX_Rd).
- BR_EX (branch operand produced in EX) = ID_Branch && IDEX_RegWr && M(IDEX_Rd).
- BR_MEM (branch operand loaded in MEM) = ID_Branch && EXMEM_MemRd && M(EXMEM_Rd).
- Stall = LU | BR_EX | BR_MEM. A load feeding a branch therefore stalls 2 cycles; an ALU result feeding a branch stalls 1 cycle.
- FSM has two states, RUN and MD_WAIT. Outputs are Mealy, combinational from state and inputs.
- RUN with Stall=1: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0. Flush is suppressed because the branch is not yet resolved.
- RUN, Stall=0, ID_Branch && ID_BranchTaken: IFID_Flush=1; PC and IF/ID writes remain enabled.
- RUN, Stall=0, ID_IsMD: MD_Start=1 for that cycle; next state is MD_WAIT. A stalled MD instruction does not start.
- RUN, otherwise: PCWrite=1, IFIDWrite=1, all other control outputs 0.
- MD_WAIT, MD_Done=0: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, MD_Busy=1. Hazard terms, branch and ID_IsMD are ignored.
- MD_WAIT, MD_Done=1: release in the same cycle (PCWrite=1, IFIDWrite=1, Bubble=0, MD_Busy=1); next state is RUN.
- MD_Done in RUN is ignored.
- Timeout: a counter of width clog2(MD_MAX_CYC+1) clears on entry to MD_WAIT and increments each MD_WAIT cycle without MD_Done.
- On the cycle where the count equals MD_MAX_CYC-1 with no MD_Done: MD_Timeout is set (sticky until rst) and next state is RUN.
- StallCnt increments on every cycle with IDEX_Bubble=1. FlushCnt increments on every cycle with IFID_Flush=1. Both hold at all-ones.
- While rst=1, outputs are forced to PCWrite=1, IFIDWrite=1, all others 0.
- On the rst edge: state goes to RUN; counters, timeout counter and MD_Timeout clear.
- A reset taken during MD_WAIT returns to RUN; a late MD_Done after that is ignored.
- There is no latency between the hazard inputs and the control outputs. State and counters update at the next edge.

Test Plan:
- Load-use: lw $8 in EX (IDEX_MemRd=1, IDEX_Rd=8), ID add reads rs=8 -> exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; StallCnt=1. Repeat with rd=0 -> no stall.
- Load feeding branch: lw $9 then beq using $9 -> 2 bubble cycles (EX match, then MEM match), then a taken beq gives IFID_Flush=1 for 1 cycle; StallCnt=2, FlushCnt=1.
- Rt-only match: IDEX_Rd=5 matches IFID_Rt=5 with ID_UsesRt=0 -> no stall. With ID_UsesRt=1 -> 1 stall.
- Mul/div handshake: ID_IsMD=1 -> MD_Start pulse 1 cycle; MD_Done arrives 10 cycles later -> frozen 10 cycles, released on the Done cycle; MD_Busy high 11 cycles; StallCnt=10.
- Timeout: MD_MAX_CYC=8, MD_Done never arrives -> MD_Timeout rises after 8 MD_WAIT cycles and the FSM returns to RUN. A later MD_Done has no effect; MD_Timeout stays 1 until rst.
- Reset mid-wait and saturation: assert rst in MD_WAIT -> RUN, counters 0, outputs at idle values. With CNT_W=4, 20 stall cycles -> StallCnt=15.
